// File: rtl/cu_hs.sv
// cu_hs: multicycle control unit with req/ack memory handshakes.
// Instruction words come from imem, data from dmem; every wait is guarded by
// a timeout counter that traps to a sticky FAULT state. HALT is sticky too.
module cu_hs #(
    parameter int BUS_WIDTH  = 16,
    parameter int OPCODE_LEN = 4,
    parameter int REG_AW     = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] ir,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    input  logic                 alu_zero,
    output logic                 imem_req,
    output logic                 dmem_read,
    output logic                 dmem_write,
    output logic                 pc_inc,
    output logic                 jump,
    output logic [REG_AW-1:0]    rf_sel_a,
    output logic [REG_AW-1:0]    rf_sel_b,
    output logic [REG_AW-1:0]    rf_sel_c,
    output logic                 rf_we,
    output logic [1:0]           wb_src,
    output logic [3:0]           alu_ctrl,
    output logic                 mar_inc,
    output logic                 col_inc,
    output logic                 row_inc,
    output logic                 col_zero,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_code
);

    // Handshake rule: a req is a level held from entry to its wait state until
    // the cycle an ack is seen with enable high; that cycle completes the
    // transfer. Acks outside a wait state are ignored.

    localparam int A_MSB = BUS_WIDTH - OPCODE_LEN - 1;
    localparam int B_MSB = A_MSB - REG_AW;
    localparam int C_MSB = B_MSB - REG_AW;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_LI_WAIT, S_LD_WAIT,
        S_ST_WAIT, S_BR_EXEC, S_BR_WAIT, S_BR_DONE, S_MAR, S_COL, S_ROW,
        S_HALT, S_FAULT
    } state_t;

    state_t                 state_q, state_d;
    logic [BUS_WIDTH-1:0]   ir_q, ir_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [3:0]             alu_q, alu_d;
    logic [1:0]             src_q, src_d;
    logic                   z_q, z_d;
    logic [1:0]             fc_q, fc_d;

    logic [OPCODE_LEN-1:0]  opcode;
    logic [31:0]            op_w;
    logic                   taken;

    // Opcode decode helpers and branch-taken evaluation from the registered zero flag
    always_comb begin
        opcode = ir_q[BUS_WIDTH-1 -: OPCODE_LEN];
        op_w   = 32'(opcode);
        taken  = (op_w[3:0] == 4'hA) ? !z_q : z_q;
    end

    // State register and datapath-control flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            alu_q   <= '0;
            src_q   <= '0;
            z_q     <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            src_q   <= src_d;
            z_q     <= z_d;
            fc_q    <= fc_d;
        end
    end

    // Next-state logic; everything freezes while enable is low
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        alu_d   = alu_q;
        src_d   = src_q;
        z_d     = z_q;
        fc_d    = fc_q;
        if (enable) begin
            case (state_q)
                S_IDLE:   state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_d    = ir;
                        state_d = S_DECODE;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = S_FAULT;
                        fc_d    = 2'd2;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    alu_d = 4'd0;
                    src_d = 2'd0;
                    if (op_w > 32'd15) begin
                        state_d = S_FAULT;
                        fc_d    = 2'd1;
                    end else begin
                        case (op_w[3:0])
                            4'h0: state_d = S_FETCH;
                            4'h1: begin state_d = S_LI_WAIT; src_d = 2'd1; end
                            4'h2: begin state_d = S_LD_WAIT; src_d = 2'd2; end
                            4'h3: state_d = S_ST_WAIT;
                            4'h4: begin state_d = S_EXEC; alu_d = 4'd3; end
                            4'h5: begin state_d = S_EXEC; alu_d = 4'd4; end
                            4'h6: begin state_d = S_EXEC; alu_d = 4'd5; end
                            4'h7: begin state_d = S_EXEC; alu_d = 4'd1; end
                            4'h8: begin state_d = S_EXEC; alu_d = 4'd2; end
                            4'h9: begin state_d = S_EXEC; alu_d = 4'd0; end
                            4'hA, 4'hB: begin state_d = S_BR_EXEC; alu_d = 4'd2; end
                            4'hC: state_d = S_MAR;
                            4'hD: state_d = S_COL;
                            4'hE: state_d = S_ROW;
                            default: state_d = S_HALT;
                        endcase
                    end
                end
                S_EXEC:    state_d = S_WB;
                S_WB:      state_d = S_FETCH;
                S_LI_WAIT: begin
                    if (imem_ack) state_d = S_WB;
                    else if (cnt_q == TMO_LAST) begin state_d = S_FAULT; fc_d = 2'd2; end
                    else cnt_d = cnt_q + 8'd1;
                end
                S_LD_WAIT: begin
                    if (dmem_ack) state_d = S_WB;
                    else if (cnt_q == TMO_LAST) begin state_d = S_FAULT; fc_d = 2'd3; end
                    else cnt_d = cnt_q + 8'd1;
                end
                S_ST_WAIT: begin
                    if (dmem_ack) state_d = S_FETCH;
                    else if (cnt_q == TMO_LAST) begin state_d = S_FAULT; fc_d = 2'd3; end
                    else cnt_d = cnt_q + 8'd1;
                end
                S_BR_EXEC: state_d = S_BR_WAIT;
                S_BR_WAIT: begin
                    // First wait cycle is the one right after EXEC: latch the compare result
                    if (cnt_q == 8'd0) z_d = alu_zero;
                    if (imem_ack) state_d = S_BR_DONE;
                    else if (cnt_q == TMO_LAST) begin state_d = S_FAULT; fc_d = 2'd2; end
                    else cnt_d = cnt_q + 8'd1;
                end
                S_BR_DONE, S_MAR, S_COL, S_ROW: state_d = S_FETCH;
                default: state_d = state_q;
            endcase
            // Any state change restarts the wait counter for the next wait
            if (state_d != state_q) cnt_d = '0;
        end
    end

    // Output decode from the current state; pulses are suppressed while frozen
    always_comb begin
        imem_req   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        pc_inc     = 1'b0;
        jump       = 1'b0;
        rf_we      = 1'b0;
        wb_src     = 2'd0;
        alu_ctrl   = 4'd0;
        mar_inc    = 1'b0;
        col_inc    = 1'b0;
        row_inc    = 1'b0;
        col_zero   = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        fault_code = 2'd0;
        rf_sel_a   = ir_q[A_MSB -: REG_AW];
        rf_sel_b   = ir_q[B_MSB -: REG_AW];
        rf_sel_c   = ir_q[C_MSB -: REG_AW];
        case (state_q)
            S_FETCH, S_LI_WAIT, S_BR_WAIT: imem_req = 1'b1;
            S_DECODE:  pc_inc = 1'b1;
            S_EXEC: begin
                alu_ctrl = alu_q;
                wb_src   = src_q;
            end
            S_WB: begin
                rf_we    = 1'b1;
                alu_ctrl = alu_q;
                wb_src   = src_q;
                pc_inc   = (src_q == 2'd1);
            end
            S_LD_WAIT: dmem_read  = 1'b1;
            S_ST_WAIT: dmem_write = 1'b1;
            S_BR_EXEC: alu_ctrl = alu_q;
            S_BR_DONE: begin
                jump   = taken;
                pc_inc = !taken;
            end
            S_MAR: mar_inc = 1'b1;
            S_COL: col_inc = 1'b1;
            S_ROW: begin
                row_inc  = 1'b1;
                col_zero = 1'b1;
            end
            S_HALT: halted = 1'b1;
            S_FAULT: begin
                fault      = 1'b1;
                fault_code = fc_q;
                rf_sel_a   = '0;
                rf_sel_b   = '0;
                rf_sel_c   = '0;
            end
            default: ;
        endcase
        if (!enable) begin
            pc_inc   = 1'b0;
            jump     = 1'b0;
            rf_we    = 1'b0;
            mar_inc  = 1'b0;
            col_inc  = 1'b0;
            row_inc  = 1'b0;
            col_zero = 1'b0;
        end
    end

endmodule

// File: tb/tb_cu_hs.sv
// tb_cu_hs: scenario tasks for cu_hs with an expected-writeback queue.
// Inputs change on the falling edge; outputs are sampled there as well.
module tb_cu_hs;

    localparam int SB_W = 10;   // {wb_src[1:0], alu_ctrl[3:0], rf_sel_c[3:0]}

    logic        clk = 1'b0;
    logic        reset, enable, imem_ack, dmem_ack, alu_zero;
    logic [15:0] ir;
    logic        imem_req, dmem_read, dmem_write, pc_inc, jump, rf_we;
    logic [3:0]  rf_sel_a, rf_sel_b, rf_sel_c, alu_ctrl;
    logic [1:0]  wb_src, fault_code;
    logic        mar_inc, col_inc, row_inc, col_zero, halted, fault;
    logic [31:0] all_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [SB_W-1:0] exp_q[$];

    assign all_out = {imem_req, dmem_read, dmem_write, pc_inc, jump, rf_sel_a, rf_sel_b,
                      rf_sel_c, rf_we, wb_src, alu_ctrl, mar_inc, col_inc, row_inc,
                      col_zero, halted, fault, fault_code};

    // Clock and global time bound
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    cu_hs dut (
        .clk(clk), .reset(reset), .enable(enable), .ir(ir),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
        .imem_req(imem_req), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .pc_inc(pc_inc), .jump(jump), .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b),
        .rf_sel_c(rf_sel_c), .rf_we(rf_we), .wb_src(wb_src), .alu_ctrl(alu_ctrl),
        .mar_inc(mar_inc), .col_inc(col_inc), .row_inc(row_inc), .col_zero(col_zero),
        .halted(halted), .fault(fault), .fault_code(fault_code)
    );

    // Driver: reset pulse; returns at the first falling edge after release
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Driver: serve one instruction fetch; returns at the DECODE falling edge
    task automatic do_fetch(input logic [15:0] w, input int dly, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) return;
        repeat (dly) @(negedge clk);
        ir = w;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        ir = 16'($urandom_range(0, 65535));
        ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        alu_zero = 1'b0; ir = 16'h0;
        repeat (2) @(negedge clk);
        n_checks++; if (all_out !== 32'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", all_out, 32'h0); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_fetch_req: got %b want 1", imem_req); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({imem_req, halted, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_mid_fetch: got %b want 000", {imem_req, halted, fault}); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL refetch_after_reset: got %b want 1", imem_req); end
    endtask

    task automatic test_alu();
        int op_tab[6]  = '{7, 8, 9, 4, 5, 6};
        int alu_tab[6] = '{1, 2, 0, 3, 4, 5};
        bit ok;
        logic [3:0] a, b, c, alu_e;
        logic [SB_W-1:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 4'd1 : 4'($urandom_range(0, 15));
            b = (i == 0) ? 4'd2 : 4'($urandom_range(0, 15));
            c = (i == 0) ? 4'd3 : 4'($urandom_range(0, 15));
            alu_e = 4'(alu_tab[i]);
            do_fetch({4'(op_tab[i]), a, b, c}, (i == 0) ? 0 : $urandom_range(0, 3), ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL alu_fetch: no imem_req op=%0d", op_tab[i]); end
            n_checks++; if ({pc_inc, imem_req} !== 2'b10) begin n_fail++; $display("FAIL alu_decode op=%0d: got %b want 10", op_tab[i], {pc_inc, imem_req}); end
            exp_q.push_back({2'd0, alu_e, c});
            @(negedge clk);
            n_checks++; if ({alu_ctrl, rf_sel_a, rf_sel_b, rf_sel_c, wb_src, rf_we} !== {alu_e, a, b, c, 2'd0, 1'b0}) begin
                n_fail++; $display("FAIL alu_exec op=%0d: got %h want %h", op_tab[i],
                    {alu_ctrl, rf_sel_a, rf_sel_b, rf_sel_c, wb_src, rf_we}, {alu_e, a, b, c, 2'd0, 1'b0}); end
            @(negedge clk);
            got = {wb_src, alu_ctrl, rf_sel_c};
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            n_checks++; if (rf_we !== 1'b1 || got !== exp) begin n_fail++; $display("FAIL alu_wb op=%0d: rf_we=%b got %h want %h", op_tab[i], rf_we, got, exp); end
            @(negedge clk);
            n_checks++; if ({rf_we, imem_req} !== 2'b01) begin n_fail++; $display("FAIL alu_refetch op=%0d: got %b want 01", op_tab[i], {rf_we, imem_req}); end
        end
    endtask

    task automatic test_loadim();
        bit ok;
        int pcs, reqs;
        logic [SB_W-1:0] got, exp;
        do_fetch(16'h1005, 0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL loadim_fetch: no imem_req"); end
        pcs = int'(pc_inc);
        reqs = 0;
        exp_q.push_back({2'd1, 4'd0, 4'd5});
        @(negedge clk);
        repeat (4) begin
            reqs += int'(imem_req);
            pcs += int'(pc_inc);
            @(negedge clk);
        end
        reqs += int'(imem_req);
        imem_ack = 1'b1; ir = 16'hBEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        pcs += int'(pc_inc);
        got = {wb_src, alu_ctrl, rf_sel_c};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++; if (rf_we !== 1'b1 || got !== exp) begin n_fail++; $display("FAIL loadim_wb: rf_we=%b got %h want %h", rf_we, got, exp); end
        @(negedge clk);
        pcs += int'(pc_inc);
        n_checks++; if (reqs !== 5) begin n_fail++; $display("FAIL loadim_req_cycles: got %0d want 5", reqs); end
        n_checks++; if (pcs !== 2) begin n_fail++; $display("FAIL loadim_pc_inc: got %0d want 2", pcs); end
    endtask

    task automatic test_branch();
        bit ok;
        logic op_a, z, tk;
        for (int i = 0; i < 4; i++) begin
            op_a = (i < 2);
            z    = i[0];
            tk   = op_a ? !z : z;
            do_fetch(op_a ? 16'hA120 : 16'hB340, $urandom_range(0, 2), ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL br_fetch: no imem_req case %0d", i); end
            @(negedge clk);
            n_checks++; if (alu_ctrl !== 4'd2) begin n_fail++; $display("FAIL br_exec_alu case %0d: got %0d want 2", i, alu_ctrl); end
            alu_zero = z;
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL br_target_req case %0d: got %b want 1", i, imem_req); end
            imem_ack = 1'b1;
            @(negedge clk);
            imem_ack = 1'b0;
            alu_zero = !z;
            n_checks++; if ({jump, pc_inc} !== {tk, !tk}) begin n_fail++; $display("FAIL br_resolve case %0d: got %b want %b", i, {jump, pc_inc}, {tk, !tk}); end
            @(negedge clk);
            n_checks++; if ({jump, pc_inc, imem_req} !== 3'b001) begin n_fail++; $display("FAIL br_refetch case %0d: got %b want 001", i, {jump, pc_inc, imem_req}); end
        end
    endtask

    task automatic test_mem_and_counters();
        bit ok;
        int wes = 0;
        logic [15:0] w_tab[3] = '{16'hC000, 16'hD000, 16'hE000};
        logic [3:0]  p_tab[3] = '{4'b1000, 4'b0100, 4'b0011};
        do_fetch(16'h3000, 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL store_fetch: no imem_req"); end
        @(negedge clk);
        repeat (2) begin
            n_checks++; if (dmem_write !== 1'b1) begin n_fail++; $display("FAIL store_write_level: got %b want 1", dmem_write); end
            wes += int'(rf_we);
            @(negedge clk);
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        n_checks++; if ({dmem_write, imem_req, wes[0]} !== 3'b010) begin n_fail++; $display("FAIL store_done: got %b want 010", {dmem_write, imem_req, wes[0]}); end
        for (int i = 0; i < 3; i++) begin
            do_fetch(w_tab[i], 0, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL cnt_fetch: no imem_req %0d", i); end
            @(negedge clk);
            n_checks++; if ({mar_inc, col_inc, row_inc, col_zero} !== p_tab[i]) begin n_fail++; $display("FAIL cnt_pulse %h: got %b want %b", w_tab[i], {mar_inc, col_inc, row_inc, col_zero}, p_tab[i]); end
            @(negedge clk);
            n_checks++; if ({mar_inc, col_inc, row_inc, col_zero, imem_req} !== 5'b00001) begin n_fail++; $display("FAIL cnt_after %h: got %b want 00001", w_tab[i], {mar_inc, col_inc, row_inc, col_zero, imem_req}); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int waits;
        logic [SB_W-1:0] got, exp;
        do_reset();
        waits = 0;
        repeat (15) begin
            if (imem_req === 1'b1 && fault === 1'b0) waits++;
            @(negedge clk);
        end
        n_checks++; if (waits !== 15) begin n_fail++; $display("FAIL imem_tmo_wait: got %0d want 15", waits); end
        n_checks++; if ({fault, fault_code, imem_req} !== 4'b1100) begin n_fail++; $display("FAIL imem_tmo_fault: got %b want 1100", {fault, fault_code, imem_req}); end
        do_reset();
        do_fetch(16'h2004, 0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL load_fetch: no imem_req"); end
        @(negedge clk);
        waits = 0;
        repeat (15) begin
            if (dmem_read === 1'b1 && fault === 1'b0) waits++;
            @(negedge clk);
        end
        n_checks++; if (waits !== 15) begin n_fail++; $display("FAIL dmem_tmo_wait: got %0d want 15", waits); end
        n_checks++; if ({fault, fault_code, dmem_read, rf_we} !== 5'b11100) begin n_fail++; $display("FAIL dmem_tmo_fault: got %b want 11100", {fault, fault_code, dmem_read, rf_we}); end
        do_reset();
        do_fetch(16'h2009, 0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL load2_fetch: no imem_req"); end
        exp_q.push_back({2'd2, 4'd0, 4'd9});
        @(negedge clk);
        repeat (14) @(negedge clk);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        got = {wb_src, alu_ctrl, rf_sel_c};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++; if (fault !== 1'b0 || rf_we !== 1'b1 || got !== exp) begin n_fail++; $display("FAIL load_late_ack: fault=%b rf_we=%b got %h want %h", fault, rf_we, got, exp); end
        @(negedge clk);
    endtask

    task automatic test_enable();
        bit ok;
        int wes = 0;
        logic [SB_W-1:0] got, exp;
        do_fetch(16'h8456, 0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL en_fetch: no imem_req"); end
        exp_q.push_back({2'd0, 4'd2, 4'd6});
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        #1;
        repeat (3) begin
            wes += int'(rf_we);
            @(negedge clk);
        end
        wes += int'(rf_we);
        n_checks++; if (wes !== 0) begin n_fail++; $display("FAIL en_frozen_we: got %0d want 0", wes); end
        enable = 1'b1;
        #1;
        got = {wb_src, alu_ctrl, rf_sel_c};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++; if (rf_we !== 1'b1 || got !== exp) begin n_fail++; $display("FAIL en_resume_wb: rf_we=%b got %h want %h", rf_we, got, exp); end
        @(negedge clk);
        n_checks++; if ({rf_we, imem_req} !== 2'b01) begin n_fail++; $display("FAIL en_after: got %b want 01", {rf_we, imem_req}); end
    endtask

    task automatic test_halt();
        bit ok;
        int reqs = 0;
        do_fetch(16'hF000, 0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL halt_fetch: no imem_req"); end
        @(negedge clk);
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
        repeat (20) begin
            reqs += int'(imem_req | dmem_read | dmem_write);
            imem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        imem_ack = 1'b0;
        n_checks++; if (reqs !== 0 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: reqs=%0d halted=%b want 0/1", reqs, halted); end
        do_reset();
        n_checks++; if ({halted, imem_req} !== 2'b01) begin n_fail++; $display("FAIL halt_reset: got %b want 01", {halted, imem_req}); end
    endtask

    // Scenario sequence and final report
    initial begin
        test_reset();
        test_alu();
        test_loadim();
        test_branch();
        test_mem_and_counters();
        test_timeout();
        test_enable();
        test_halt();
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cu_hs.md
Name: cu_hs

Overview:
- Parametrised multicycle control unit for the processor datapath, replacing the fixed-timing FSM controller.
- Fetches instruction words from imem and data from dmem over req/ack handshakes instead of fixed delays.
- Adds a conditional-branch pair (JUMPNZ/JUMPZ), a stall-timeout fault, an illegal-opcode trap, and a sticky HALT.
- Drives register-file selects, the ALU, PC, MAR and row/column counters.

Parameters:
BUS_WIDTH, 16, instruction/bus word width
OPCODE_LEN, 4, opcode field width (must be ≥4); values ≥16 are illegal
REG_AW, 4, width of each register-select field (A, B, C)
TIMEOUT, 15, max cycles a req may wait for ack before fault (1..255)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
enable  in  1  0 = freeze FSM and timeout counter
ir  in  BUS_WIDTH  imem read data; captured into internal IR on the imem_ack cycle
imem_ack  in  1  imem data valid this cycle
dmem_ack  in  1  dmem read data valid or write accepted this cycle
alu_zero  in  1  ALU result == 0
imem_req  out  1  level; held until ack
dmem_read  out  1  level; held until dmem_ack
dmem_write  out  1  level; held until dmem_ack
pc_inc  out  1  1-cycle pulse
jump  out  1  1-cycle pulse; PC loads bus
rf_sel_a / rf_sel_b / rf_sel_c  out  REG_AW each  IR fields [op-1 -: REG_AW] in order A, B, C
rf_we  out  1  1-cycle write strobe for reg C
wb_src  out  2  0 ALU, 1 imem word, 2 dmem word
alu_ctrl  out  4  0 pass, 1 add, 2 sub, 3 shl1, 4 shl2, 5 shr4
mar_inc, col_inc, row_inc, col_zero  out  1 each  1-cycle pulses
halted  out  1  sticky until reset
fault  out  1  sticky until reset
fault_code  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout

Behaviour:
- Reset: all outputs 0, state IDLE, IR 0, timeout counter 0. Reset mid-handshake drops every req on the next edge.
- IDLE → FETCH on the first enabled cycle.
- enable=0: state, IR and counter hold. Level requests hold. All pulse outputs and rf_we are forced 0.
- FETCH: imem_req=1. On the imem_ack cycle, IR←ir and the next state is DECODE. Next cycle: pc_inc=1, imem_req=0.
- DECODE (1 cycle) dispatches on IR opcode:
  - 0 NOP→FETCH
  - 1 LOADIM
  - 2 LOAD
  - 3 STORE
  - 4/5/6 shifts
  - 7 ADD, 8 SUB, 9 MOVE
  - A JUMPNZ, B JUMPZ
  - C MAR_INC, D COL_INC, E ROW_INC
  - F HALT
  - ≥16 → FAULT, code 1
- ALU ops, EXEC→WB:
  - EXEC: alu_ctrl set (shifts 3/4/5, ADD 1, SUB 2, MOVE 0), wb_src=0.
  - WB: rf_we=1 with alu_ctrl held, then FETCH.
  - DECODE to next imem_req = 3 cycles.
- LOADIM: imem_req until ack, then WB with wb_src=1 and rf_we=1. pc_inc pulses on the cycle after ack.
- LOAD: dmem_read until ack, then WB with wb_src=2 and rf_we=1.
- STORE: dmem_write until ack, then FETCH. No rf_we.
- JUMPNZ/JUMPZ: target is the next imem word.
  - EXEC: alu_ctrl=2 (A−B).
  - Then imem_req for the target.
  - On ack: taken (JUMPNZ with alu_zero=0, or JUMPZ with alu_zero=1) → jump=1; else → pc_inc=1. Then FETCH.
  - alu_zero is sampled on the EXEC+1 cycle and registered.
- MAR_INC/COL_INC: one pulse cycle, then FETCH.
- ROW_INC: row_inc=1 and col_zero=1 in the same cycle, then FETCH.
- HALT: halted=1, no further requests; exit only by reset.
- Timeout: counter clears on entry to every wait and increments each enabled cycle with req high and no ack.
  - When the count reaches TIMEOUT without ack → FAULT, code 2 (imem) or 3 (dmem), req deasserted.
  - Ack arriving on the same cycle the count reaches TIMEOUT wins (no fault).
- FAULT: all outputs 0 except fault and fault_code; held until reset.
- Ack while no req is pending is ignored. An ack arriving in the same cycle as req assertion completes that cycle.

Test Plan:
- Reset mid-fetch: imem_req=1, assert reset → next edge imem_req=0, halted=0, fault=0; first enabled cycle after release raises imem_req.
- ADD, IR=0x7123, imem_ack immediate → DECODE, EXEC alu_ctrl=1 rf_sel_a=1 rf_sel_b=2 rf_sel_c=3, then WB rf_we=1 for exactly 1 cycle, imem_req 3 cycles after DECODE.
- LOADIM with imem_ack delayed 4 cycles → imem_req held 5 cycles, pc_inc pulses twice total, rf_we=1 with wb_src=1.
- JUMPNZ: alu_zero=0 → jump=1 and pc_inc=0; repeat with alu_zero=1 → jump=0, pc_inc=1; JUMPZ gives mirror results.
- dmem_ack never arrives on LOAD, TIMEOUT=15 → fault=1, fault_code=3 after 15 waiting cycles; ack on cycle 15 instead → no fault.
- enable toggled low during WB → rf_we stays 0 while low, fires once on resume. Opcode 0xF → halted=1, no further imem_req for 20 cycles.
